tl_perm_tracker: RTL and testbench

Client-side TileLink permission tracker for a parametrised set of cache line entries. Holds a 2-bit permission (Nothing/Branch/Trunk/Dirty) plus an acquire-pending flag per entry. Turns cache-controller events (acquire, grant, probe, release, write-mark) into the matching grow/cap/shrink/report parameter, with has-data and error indications. Sits between the L1 controller and the A/C-channel message builders; encodings come from the TLBundleParam package.

---
 rtl/tl_perm_tracker.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_tl_perm_tracker.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_perm_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tl_perm_tracker
//  Purpose  : Client-side TileLink permission tracker. Keeps a 2-bit
//             permission (N/B/T/D) and an acquire-pending flag per cache
//             line entry. Converts controller events (acquire, grant,
//             probe, release, write-mark) into the matching TileLink
//             grow / cap / shrink-report parameter, with has-data and
//             error indications.
//  Ports    : clock, reset          - clock, synchronous active-high reset
//             req_valid/req_ready   - request handshake (ready only when idle)
//             req_op/idx/param      - operation, entry index, op parameter
//             resp_valid/resp_ready - response handshake
//             resp_param/hit/has_data/error/idx - registered response fields
//             perm_o                - permission of entry i at [2i+1:2i]
//             pending_o             - acquire-pending flag per entry
//  Revision : 1.0 - initial release
// ============================================================================
module tl_perm_tracker #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [IDX_W-1:0]       req_idx,
    input  logic [2:0]             req_param,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [2:0]             resp_param,
    output logic                   resp_hit,
    output logic                   resp_has_data,
    output logic                   resp_error,
    output logic [IDX_W-1:0]       resp_idx,
    output logic [2*ENTRIES-1:0]   perm_o,
    output logic [ENTRIES-1:0]     pending_o
);

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Operations
    localparam logic [2:0] OP_ACQUIRE = 3'd0;
    localparam logic [2:0] OP_GRANT   = 3'd1;
    localparam logic [2:0] OP_PROBE   = 3'd2;
    localparam logic [2:0] OP_RELEASE = 3'd3;
    localparam logic [2:0] OP_WRITE   = 3'd4;

    // Permissions
    localparam logic [1:0] PERM_N = 2'd0;
    localparam logic [1:0] PERM_B = 2'd1;
    localparam logic [1:0] PERM_T = 2'd2;
    localparam logic [1:0] PERM_D = 2'd3;

    // Cap codes
    localparam logic [2:0] CAP_TOT = 3'd0;
    localparam logic [2:0] CAP_TOB = 3'd1;
    localparam logic [2:0] CAP_TON = 3'd2;

    // Grow codes
    localparam logic [2:0] GROW_NTOB = 3'd0;
    localparam logic [2:0] GROW_NTOT = 3'd1;
    localparam logic [2:0] GROW_BTOT = 3'd2;

    // Shrink / report codes
    localparam logic [2:0] RPT_TTOB = 3'd0;
    localparam logic [2:0] RPT_TTON = 3'd1;
    localparam logic [2:0] RPT_BTON = 3'd2;
    localparam logic [2:0] RPT_TTOT = 3'd3;
    localparam logic [2:0] RPT_BTOB = 3'd4;
    localparam logic [2:0] RPT_NTON = 3'd5;

    localparam logic [31:0] NUM_ENTRIES = ENTRIES;

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q;
    logic [IDX_W-1:0]   idx_q;
    logic [2:0]         param_q;

    logic [1:0]         perm_q [ENTRIES];
    logic [ENTRIES-1:0] pend_q;

    logic [2:0]         resp_param_q;
    logic               resp_hit_q;
    logic               resp_has_data_q;
    logic               resp_error_q;
    logic [IDX_W-1:0]   resp_idx_q;

    logic               w_idx_ok;
    logic [IDX_W-1:0]   w_sel;
    logic [1:0]         w_cur_perm;
    logic               w_cur_pend;
    logic               w_err;
    logic               w_hit;
    logic               w_hd;
    logic [2:0]         w_param;
    logic [1:0]         w_new_perm;
    logic               w_new_pend;
    logic               w_wr;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid)  state_d = ST_EXEC;
            ST_EXEC:                 state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
    end

    // ------------------------------------------------------------------
    // Entry lookup. An out-of-range index is steered to entry 0 so the
    // table read stays in bounds; the request is flagged as an error and
    // never writes.
    // ------------------------------------------------------------------
    assign w_idx_ok   = ({{(32-IDX_W){1'b0}}, idx_q} < NUM_ENTRIES);
    assign w_sel      = w_idx_ok ? idx_q : '0;
    assign w_cur_perm = perm_q[w_sel];
    assign w_cur_pend = pend_q[w_sel];

    // ------------------------------------------------------------------
    // Result computation for the latched request (used in EXEC)
    // ------------------------------------------------------------------
    always_comb begin
        w_err      = 1'b0;
        w_hit      = 1'b0;
        w_hd       = 1'b0;
        w_param    = 3'd0;
        w_new_perm = w_cur_perm;
        w_new_pend = w_cur_pend;
        w_wr       = 1'b0;

        if (!w_idx_ok || (op_q > OP_WRITE)) begin
            w_err = 1'b1;
        end else begin
            case (op_q)
                OP_ACQUIRE: begin
                    if (w_cur_pend || (param_q > 3'd1)) begin
                        w_err = 1'b1;
                    end else if (param_q[0] ? (w_cur_perm >= PERM_T)
                                            : (w_cur_perm != PERM_N)) begin
                        w_hit = 1'b1;
                    end else begin
                        // Permission itself only moves when the grant lands.
                        w_param    = (w_cur_perm == PERM_N)
                                   ? (param_q[0] ? GROW_NTOT : GROW_NTOB)
                                   : GROW_BTOT;
                        w_new_pend = 1'b1;
                        w_wr       = 1'b1;
                    end
                end
                OP_GRANT: begin
                    if (!w_cur_pend || (param_q >= CAP_TON)) begin
                        w_err = 1'b1;
                    end else begin
                        w_new_perm = (param_q == CAP_TOT) ? PERM_T : PERM_B;
                        w_new_pend = 1'b0;
                        w_param    = param_q;
                        w_wr       = 1'b1;
                    end
                end
                OP_PROBE: begin
                    if (param_q > CAP_TON) begin
                        w_err = 1'b1;
                    end else begin
                        w_wr = 1'b1;
                        case (w_cur_perm)
                            PERM_T, PERM_D: begin
                                if (param_q == CAP_TOT) begin
                                    w_param = RPT_TTOT;
                                end else if (param_q == CAP_TOB) begin
                                    w_param    = RPT_TTOB;
                                    w_new_perm = PERM_B;
                                end else begin
                                    w_param    = RPT_TTON;
                                    w_new_perm = PERM_N;
                                end
                            end
                            PERM_B: begin
                                if (param_q == CAP_TON) begin
                                    w_param    = RPT_BTON;
                                    w_new_perm = PERM_N;
                                end else begin
                                    w_param = RPT_BTOB;
                                end
                            end
                            default: w_param = RPT_NTON;
                        endcase
                        // Dirty data leaves only when the line is downgraded.
                        w_hd = (w_cur_perm == PERM_D) && (param_q != CAP_TOT);
                    end
                end
                OP_RELEASE: begin
                    if (w_cur_pend || (w_cur_perm == PERM_N)) begin
                        w_err = 1'b1;
                    end else begin
                        w_param    = (w_cur_perm == PERM_B) ? RPT_BTON : RPT_TTON;
                        w_hd       = (w_cur_perm == PERM_D);
                        w_new_perm = PERM_N;
                        w_wr       = 1'b1;
                    end
                end
                OP_WRITE: begin
                    if ((w_cur_perm == PERM_T) || (w_cur_perm == PERM_D)) begin
                        w_new_perm = PERM_D;
                        w_wr       = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: w_err = 1'b1;
            endcase
        end

        if (w_err) begin
            w_param = 3'd0;
            w_hit   = 1'b0;
            w_hd    = 1'b0;
            w_wr    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Request latch, tables and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q            <= '0;
            idx_q           <= '0;
            param_q         <= '0;
            pend_q          <= '0;
            resp_param_q    <= '0;
            resp_hit_q      <= 1'b0;
            resp_has_data_q <= 1'b0;
            resp_error_q    <= 1'b0;
            resp_idx_q      <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                perm_q[i] <= PERM_N;
            end
        end else begin
            if ((state_q == ST_IDLE) && req_valid) begin
                op_q    <= req_op;
                idx_q   <= req_idx;
                param_q <= req_param;
            end
            if (state_q == ST_EXEC) begin
                resp_param_q    <= w_param;
                resp_hit_q      <= w_hit;
                resp_has_data_q <= w_hd;
                resp_error_q    <= w_err;
                resp_idx_q      <= idx_q;
                if (w_wr) begin
                    perm_q[w_sel] <= w_new_perm;
                    pend_q[w_sel] <= w_new_pend;
                end
            end
        end
    end

    assign resp_param    = resp_param_q;
    assign resp_hit      = resp_hit_q;
    assign resp_has_data = resp_has_data_q;
    assign resp_error    = resp_error_q;
    assign resp_idx      = resp_idx_q;
    assign pending_o     = pend_q;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_perm
            assign perm_o[2*gi +: 2] = perm_q[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tl_perm_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tl_perm_tracker
//  Purpose  : Self-checking bench for tl_perm_tracker. Directed steps for
//             the key scenarios, followed by randomized traffic, all
//             compared against a behavioural permission model. A second
//             instance with six entries exercises the index-range check.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tl_perm_tracker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [2:0]  req_idx = '0;
    logic [2:0]  req_param = '0;
    logic        resp_ready = 1'b0;
    logic        sel6 = 1'b0;

    // Eight-entry instance
    logic        rr8, rv8, hit8, hd8, err8;
    logic [2:0]  par8, ridx8;
    logic [15:0] perm8;
    logic [7:0]  pend8;
    // Six-entry instance
    logic        rr6, rv6, hit6, hd6, err6;
    logic [2:0]  par6, ridx6;
    logic [11:0] perm6;
    logic [5:0]  pend6;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    tl_perm_tracker #(.ENTRIES(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid & ~sel6), .req_ready(rr8),
        .req_op(req_op), .req_idx(req_idx), .req_param(req_param),
        .resp_valid(rv8), .resp_ready(resp_ready),
        .resp_param(par8), .resp_hit(hit8), .resp_has_data(hd8),
        .resp_error(err8), .resp_idx(ridx8),
        .perm_o(perm8), .pending_o(pend8)
    );

    tl_perm_tracker #(.ENTRIES(6)) dut6 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid & sel6), .req_ready(rr6),
        .req_op(req_op), .req_idx(req_idx), .req_param(req_param),
        .resp_valid(rv6), .resp_ready(resp_ready),
        .resp_param(par6), .resp_hit(hit6), .resp_has_data(hd6),
        .resp_error(err6), .resp_idx(ridx6),
        .perm_o(perm6), .pending_o(pend6)
    );

    // Observed signals of the instance under test
    logic        m_rr, m_rv, m_hit, m_hd, m_err;
    logic [2:0]  m_par, m_ridx;
    logic [15:0] m_perm;
    logic [7:0]  m_pend;
    assign m_rr   = sel6 ? rr6   : rr8;
    assign m_rv   = sel6 ? rv6   : rv8;
    assign m_hit  = sel6 ? hit6  : hit8;
    assign m_hd   = sel6 ? hd6   : hd8;
    assign m_err  = sel6 ? err6  : err8;
    assign m_par  = sel6 ? par6  : par8;
    assign m_ridx = sel6 ? ridx6 : ridx8;
    assign m_perm = sel6 ? {4'b0, perm6} : perm8;
    assign m_pend = sel6 ? {2'b0, pend6} : pend8;

    task automatic chk(input string tag, input bit ok,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: permission level 0..3 (N,B,T,D), pending flag
    // ------------------------------------------------------------------
    int m_perm_tab [8];
    bit m_pend_tab [8];
    // Report code indexed by from_class*3 + to_class (class N=0,B=1,T=2)
    int rpt_tab [9] = '{5, 0, 0, 2, 4, 0, 1, 0, 3};

    function automatic logic [15:0] pack_perm();
        logic [15:0] v;
        for (int i = 0; i < 8; i++) v[2*i +: 2] = m_perm_tab[i][1:0];
        return v;
    endfunction

    function automatic logic [7:0] pack_pend();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend_tab[i];
        return v;
    endfunction

    function automatic int perm_class(input int p);
        return (p >= 2) ? 2 : p;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m_perm_tab[i] = 0;
            m_pend_tab[i] = 1'b0;
        end
    endtask

    task automatic model(input int op, input int idx, input int prm, input int n_ent,
                         output logic e_err, output logic e_hit,
                         output logic e_hd, output logic [2:0] e_par);
        int cur, lim, nw, code;
        e_err = 1'b0; e_hit = 1'b0; e_hd = 1'b0; code = 0;
        if (op > 4 || idx >= n_ent) begin
            e_err = 1'b1;
        end else begin
            cur = m_perm_tab[idx];
            case (op)
                0: begin
                    if (m_pend_tab[idx] || prm > 1) e_err = 1'b1;
                    else if (cur >= prm + 1) e_hit = 1'b1;
                    else begin
                        code = (cur == 0) ? prm : 2;
                        m_pend_tab[idx] = 1'b1;
                    end
                end
                1: begin
                    if (!m_pend_tab[idx] || prm > 1) e_err = 1'b1;
                    else begin
                        m_perm_tab[idx] = (prm == 0) ? 2 : 1;
                        m_pend_tab[idx] = 1'b0;
                        code = prm;
                    end
                end
                2: begin
                    if (prm > 2) e_err = 1'b1;
                    else begin
                        lim  = (prm == 0) ? 3 : (prm == 1) ? 1 : 0;
                        nw   = (cur > lim) ? lim : cur;
                        code = rpt_tab[perm_class(cur)*3 + perm_class(nw)];
                        e_hd = (cur == 3) && (nw < cur);
                        m_perm_tab[idx] = nw;
                    end
                end
                3: begin
                    if (m_pend_tab[idx] || cur == 0) e_err = 1'b1;
                    else begin
                        code = (cur >= 2) ? 1 : 2;
                        e_hd = (cur == 3);
                        m_perm_tab[idx] = 0;
                    end
                end
                default: begin
                    if (cur >= 2) m_perm_tab[idx] = 3;
                    else e_err = 1'b1;
                end
            endcase
        end
        if (e_err) begin
            code = 0; e_hit = 1'b0; e_hd = 1'b0;
        end
        e_par = code[2:0];
    endtask

    // ------------------------------------------------------------------
    // One complete transaction with full timing and field checks
    // ------------------------------------------------------------------
    task automatic do_op(input int op, input int idx, input int prm,
                         input int hold, input bit abort);
        logic        e_err, e_hit, e_hd;
        logic [2:0]  e_par;
        logic [15:0] pre_perm, post_perm;
        logic [7:0]  pre_pend, post_pend;
        int          n;
        pre_perm = pack_perm();
        pre_pend = pack_pend();
        model(op, idx, prm, sel6 ? 6 : 8, e_err, e_hit, e_hd, e_par);
        post_perm = pack_perm();
        post_pend = pack_pend();

        @(negedge clock);
        req_valid = 1'b1;
        req_op    = op[2:0];
        req_idx   = idx[2:0];
        req_param = prm[2:0];
        n = 0;
        while (m_rr !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (m_rr !== 1'b1) begin
            chk("accept_timeout", m_rr === 1'b1, m_rr, 1'b1);
            req_valid = 1'b0;
        end else begin
            @(posedge clock); #1;                 // accept edge E0
            req_valid = 1'b0;
            chk("exec_resp_valid", m_rv === 1'b0, m_rv, 1'b0);
            chk("exec_perm_hold", m_perm === pre_perm, m_perm, pre_perm);
            chk("exec_pend_hold", m_pend === pre_pend, m_pend, pre_pend);
            @(posedge clock); #1;                 // EXEC edge E1
            chk("resp_valid", m_rv === 1'b1, m_rv, 1'b1);
            chk("req_ready_busy", m_rr === 1'b0, m_rr, 1'b0);
            chk("resp_error", m_err === e_err, m_err, e_err);
            chk("resp_param", m_par === e_par, m_par, e_par);
            chk("resp_hit", m_hit === e_hit, m_hit, e_hit);
            chk("resp_has_data", m_hd === e_hd, m_hd, e_hd);
            chk("resp_idx", m_ridx === idx[2:0], m_ridx, idx[2:0]);
            chk("perm", m_perm === post_perm, m_perm, post_perm);
            chk("pending", m_pend === post_pend, m_pend, post_pend);
            for (int c = 0; c < hold; c++) begin
                @(posedge clock); #1;
                chk("hold_valid", m_rv === 1'b1, m_rv, 1'b1);
                chk("hold_ready", m_rr === 1'b0, m_rr, 1'b0);
                chk("hold_param", m_par === e_par, m_par, e_par);
                chk("hold_flags", {m_err, m_hit, m_hd} === {e_err, e_hit, e_hd},
                    {m_err, m_hit, m_hd}, {e_err, e_hit, e_hd});
            end
            if (abort) begin
                @(negedge clock);
                reset = 1'b1;
                @(posedge clock); #1;
                clear_model();
                chk("abort_resp_valid", m_rv === 1'b0, m_rv, 1'b0);
                chk("abort_pending", m_pend === 8'h00, m_pend, 8'h00);
                chk("abort_perm", m_perm === 16'h0000, m_perm, 16'h0000);
                @(negedge clock);
                reset = 1'b0;
                @(posedge clock); #1;
                chk("abort_req_ready", m_rr === 1'b1, m_rr, 1'b1);
            end else begin
                resp_ready = 1'b1;
                @(posedge clock); #1;             // retire edge
                resp_ready = 1'b0;
                chk("retire_valid", m_rv === 1'b0, m_rv, 1'b0);
                chk("retire_ready", m_rr === 1'b1, m_rr, 1'b1);
            end
        end
    endtask

    initial begin
        int r, op, idx, prm;
        clear_model();

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_req_ready", rr8 === 1'b1, rr8, 1'b1);
        chk("rst_resp_valid", rv8 === 1'b0, rv8, 1'b0);
        chk("rst_resp_fields", {par8, hit8, hd8, err8, ridx8} === 9'h000,
            {par8, hit8, hd8, err8, ridx8}, 9'h000);
        chk("rst_perm", perm8 === 16'h0000, perm8, 16'h0000);
        chk("rst_pending", pend8 === 8'h00, pend8, 8'h00);

        // Index out of range on the six-entry instance
        sel6 = 1'b1;
        do_op(0, 7, 1, 0, 1'b0);
        do_op(4, 6, 0, 0, 1'b0);
        sel6 = 1'b0;

        // Acquire / grant / write / probe sequence on entry 3
        do_op(0, 3, 1, 0, 1'b0);   // NtoT, pending
        do_op(1, 3, 0, 0, 1'b0);   // toT -> Trunk
        do_op(4, 3, 0, 0, 1'b0);   // Trunk -> Dirty
        do_op(2, 3, 1, 0, 1'b0);   // TtoB with data
        do_op(2, 3, 0, 0, 1'b0);   // BtoB

        // Error cases
        do_op(1, 5, 0, 0, 1'b0);   // grant with nothing pending
        do_op(0, 1, 0, 0, 1'b0);
        do_op(0, 1, 0, 0, 1'b0);   // second acquire on pending line
        do_op(4, 3, 0, 0, 1'b0);   // write on Branch
        do_op(6, 2, 0, 0, 1'b0);   // illegal op
        do_op(0, 2, 2, 0, 1'b0);   // acquire with bad need
        do_op(1, 1, 2, 0, 1'b0);   // grant toN
        do_op(1, 1, 1, 0, 1'b0);   // grant toB -> Branch

        // Dirty release, then release of an empty line
        do_op(0, 3, 1, 0, 1'b0);   // BtoT
        do_op(1, 3, 0, 0, 1'b0);
        do_op(4, 3, 0, 0, 1'b0);
        do_op(3, 3, 0, 0, 1'b0);   // TtoN with data
        do_op(3, 3, 0, 0, 1'b0);   // error

        // Response back-pressure
        do_op(0, 6, 0, 5, 1'b0);
        do_op(1, 6, 0, 5, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 250; k++) begin
            r   = $urandom_range(0, 15);
            op  = (r < 14) ? (r % 5) : (r - 9);
            idx = $urandom_range(0, 7);
            prm = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
            do_op(op, idx, prm, $urandom_range(0, 2), 1'b0);
        end

        // Reset during the response of a pending acquire
        do_op(3, 0, 0, 0, 1'b1);   // aborts whatever, leaves clean tables
        do_op(0, 2, 0, 0, 1'b0);
        do_op(1, 2, 0, 0, 1'b0);   // entry 2 Trunk
        do_op(0, 4, 1, 1, 1'b1);   // pending acquire, reset in RESP

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        n_err++;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
